alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: DATA_W, default 32, datapath width of operands and result; only 32 is supported.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: opcode  input  6  instruction opcode field [31:26].
REQ-005 Port: rs_content  input  32  rs register operand.
REQ-006 Port: rt_content  input  32  rt register operand.
REQ-007 Port: shamt  input  5  shift amount field.
REQ-008 Port: ALU_control  input  6  R-type funct field; used only when opcode = 000000.
REQ-009 Port: immediate  input  16  I-type immediate field.
REQ-010 Port: ALU_result  output  32  registered operation result.
REQ-011 Port: sig_branch  output  1  registered branch-taken flag.

Function
REQ-012 A combinational result and branch value are computed from the current inputs and captured into ALU_result/sig_branch on every rising clk edge; latency is exactly 1 cycle, with no enable and no handshake.
REQ-013 Immediate extension: SIMM = sign-extended immediate; ZIMM = zero-extended immediate.
REQ-014 R-type (opcode 000000), selected by ALU_control:
- 100000/100001 add/addu: rs+rt, modulo 2^32, no overflow trap.
- 100010/100011 sub/subu: rs-rt, modulo 2^32.
- 100100 and; 100101 or; 100110 xor; 100111 nor.
- 101010 slt: signed rs<rt gives 1, else 0.
- 101011 sltu: unsigned comparison, same encoding of the result.
- 000000 sll, 000010 srl, 000011 sra: shift rt by shamt.
- 000100 sllv, 000110 srlv, 000111 srav: shift rt by rs[4:0].
REQ-015 I-type, selected by opcode:
- 001000/001001 addi/addiu: rs+SIMM.
- 001010 slti: signed rs<SIMM; 001011 sltiu: unsigned rs<SIMM.
- 001100 andi, 001101 ori, 001110 xori: use ZIMM.
- 001111 lui: {immediate,16'h0}.
- 100011 lw and 101011 sw: address rs+SIMM.
REQ-016 Branches: opcode 000100 (beq) gives sig_branch=1 iff rs==rt; opcode 000101 (bne) gives sig_branch=1 iff rs!=rt; ALU_result=rs-rt for both.
REQ-017 sig_branch is 0 for every non-branch opcode.
REQ-018 Any unlisted opcode, or unlisted funct under opcode 000000, yields ALU_result=0 and sig_branch=0.
REQ-019 sra/srav replicate rt[31]; srl/srlv/sll/sllv fill with zeros; shift amount 0 passes rt unchanged.
REQ-020 Signed compares must be correct at the extremes: 0x80000000 < 0x7FFFFFFF gives 1 for slt and 0 for sltu.

Reset
REQ-021 While rst=1, ALU_result=0 and sig_branch=0 immediately, independent of clk.
REQ-022 The first capture after rst deasserts occurs on the next rising clk edge.
REQ-023 Reset asserted mid-operation discards the pending result.

Configuration
REQ-024 Macro ALU_VAR_SHIFT_EN defined: sllv/srlv/srav are implemented per REQ-014.
REQ-025 ALU_VAR_SHIFT_EN undefined: funct 000100/000110/000111 are treated as unlisted per REQ-018.

Structure
REQ-026 Package alu_pkg holds:
- opcode localparams, e.g. OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI.
- funct localparams, e.g. FN_ADD, FN_SLT, FN_SRA.
REQ-027 Sub-module alu_core is purely combinational: the same inputs produce the next result and next branch value.
REQ-028 The alu top level holds only the output registers and the reset logic.

Verification
REQ-029 beq, rs=15, rt=12 -> one cycle later sig_branch=0, ALU_result=3.
REQ-030 beq, rs=15, rt=15 -> sig_branch=1, ALU_result=0; beq, rs=5, rt=15 -> sig_branch=0, ALU_result=0xFFFFFFF6.
REQ-031 R-type sra, rt=0x80000000, shamt=4 -> ALU_result=0xF8000000; slt with rs=0x80000000, rt=1 -> 1; sltu with the same operands -> 0.
REQ-032 addi, rs=10, immediate=0xFFFF -> 9; ori, rs=0, immediate=0xFFFF -> 0x0000FFFF; lui, immediate=0x1234 -> 0x12340000.
REQ-033 rst pulsed asynchronously between clock edges while outputs are nonzero -> both outputs read 0 before the next edge; opcode 111111 -> ALU_result=0, sig_branch=0.
REQ-034 sllv, rt=1, rs=35 -> 8 with ALU_VAR_SHIFT_EN defined, 0 without it.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode/funct encodings and helpers shared by the ALU files
//
// Purpose: one place for the MIPS-style opcode [31:26] and R-type funct
//          encodings decoded by alu_core, plus small datapath helpers.
// Ports:   none (package).
// Config:  ALU_VAR_SHIFT_EN selects whether the variable shifts are decoded
//          (the encodings are always defined here).

package alu_pkg;

    localparam int XLEN = 32;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    // Set-less-than results are a single bit placed in the LSB of the word.
    function automatic logic [XLEN-1:0] flag_word(input logic b);
        return {{(XLEN-1){1'b0}}, b};
    endfunction

    function automatic logic [XLEN-1:0] sext16(input logic [15:0] imm);
        return {{(XLEN-16){imm[15]}}, imm};
    endfunction

    function automatic logic [XLEN-1:0] zext16(input logic [15:0] imm);
        return {{(XLEN-16){1'b0}}, imm};
    endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU datapath and branch decision
//
// Purpose: decodes opcode/funct and produces the next result word and the
//          next branch-taken flag from the current operands. No state.
// Ports:   opcode_i      instruction opcode [31:26]
//          funct_i       R-type funct field (only used for opcode 000000)
//          rs_i, rt_i    register operands
//          shamt_i       constant shift amount
//          immediate_i   I-type immediate
//          result_o      next ALU result
//          branch_o      next branch-taken flag
// Config:  ALU_VAR_SHIFT_EN defined -> sllv/srlv/srav decoded; undefined ->
//          those funct codes fall into the unlisted (zero) case.

module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [5:0]        opcode_i,
    input  logic [5:0]        funct_i,
    input  logic [DATA_W-1:0] rs_i,
    input  logic [DATA_W-1:0] rt_i,
    input  logic [4:0]        shamt_i,
    input  logic [15:0]       immediate_i,
    output logic [DATA_W-1:0] result_o,
    output logic              branch_o
);

    logic [DATA_W-1:0] simm;
    logic [DATA_W-1:0] zimm;

    assign simm = sext16(immediate_i);
    assign zimm = zext16(immediate_i);

    always_comb begin
        result_o = '0;
        branch_o = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADD, FN_ADDU: result_o = rs_i + rt_i;
                    FN_SUB, FN_SUBU: result_o = rs_i - rt_i;
                    FN_AND:          result_o = rs_i & rt_i;
                    FN_OR:           result_o = rs_i | rt_i;
                    FN_XOR:          result_o = rs_i ^ rt_i;
                    FN_NOR:          result_o = ~(rs_i | rt_i);
                    FN_SLT:          result_o = flag_word($signed(rs_i) < $signed(rt_i));
                    FN_SLTU:         result_o = flag_word(rs_i < rt_i);
                    FN_SLL:          result_o = rt_i << shamt_i;
                    FN_SRL:          result_o = rt_i >> shamt_i;
                    FN_SRA:          result_o = $unsigned($signed(rt_i) >>> shamt_i);
`ifdef ALU_VAR_SHIFT_EN
                    // Only the low five bits of rs select the shift distance.
                    FN_SLLV:         result_o = rt_i << rs_i[4:0];
                    FN_SRLV:         result_o = rt_i >> rs_i[4:0];
                    FN_SRAV:         result_o = $unsigned($signed(rt_i) >>> rs_i[4:0]);
`endif
                    default:         result_o = '0;
                endcase
            end
            OP_ADDI, OP_ADDIU: result_o = rs_i + simm;
            OP_SLTI:           result_o = flag_word($signed(rs_i) < $signed(simm));
            OP_SLTIU:          result_o = flag_word(rs_i < simm);
            OP_ANDI:           result_o = rs_i & zimm;
            OP_ORI:            result_o = rs_i | zimm;
            OP_XORI:           result_o = rs_i ^ zimm;
            OP_LUI:            result_o = {immediate_i, {(DATA_W-16){1'b0}}};
            OP_LW, OP_SW:      result_o = rs_i + simm;
            // Branches report the difference as well as the decision.
            OP_BEQ: begin
                result_o = rs_i - rt_i;
                branch_o = (rs_i == rt_i);
            end
            OP_BNE: begin
                result_o = rs_i - rt_i;
                branch_o = (rs_i != rt_i);
            end
            default: begin
                result_o = '0;
                branch_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - registered ALU top: output registers around alu_core
//
// Purpose: captures the combinational result/branch from alu_core on every
//          rising clk edge (1-cycle latency, no enable). rst clears both
//          outputs asynchronously.
// Ports:   clk, rst        clock, asynchronous active-high reset
//          opcode          opcode [31:26]
//          rs_content      rs operand
//          rt_content      rt operand
//          shamt           shift amount
//          ALU_control     R-type funct
//          immediate       I-type immediate
//          ALU_result      registered result
//          sig_branch      registered branch-taken flag
// Config:  ALU_VAR_SHIFT_EN (see alu_core) enables sllv/srlv/srav.

module alu
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        opcode,
    input  logic [DATA_W-1:0] rs_content,
    input  logic [DATA_W-1:0] rt_content,
    input  logic [4:0]        shamt,
    input  logic [5:0]        ALU_control,
    input  logic [15:0]       immediate,
    output logic [DATA_W-1:0] ALU_result,
    output logic              sig_branch
);

    logic [DATA_W-1:0] result_d, result_q;
    logic              branch_d, branch_q;

    alu_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .opcode_i    (opcode),
        .funct_i     (ALU_control),
        .rs_i        (rs_content),
        .rt_i        (rt_content),
        .shamt_i     (shamt),
        .immediate_i (immediate),
        .result_o    (result_d),
        .branch_o    (branch_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            branch_q <= 1'b0;
        end else begin
            result_q <= result_d;
            branch_q <= branch_d;
        end
    end

    assign ALU_result = result_q;
    assign sig_branch = branch_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed self-checking bench for alu

module tb_alu;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic [31:0] rs_content;
    logic [31:0] rt_content;
    logic [4:0]  shamt;
    logic [5:0]  ALU_control;
    logic [15:0] immediate;
    logic [31:0] ALU_result;
    logic        sig_branch;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  sh;
        logic [15:0] imm;
        logic [31:0] res;
        logic        br;
    } vec_t;

    alu #(.DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .rs_content  (rs_content),
        .rt_content  (rt_content),
        .shamt       (shamt),
        .ALU_control (ALU_control),
        .immediate   (immediate),
        .ALU_result  (ALU_result),
        .sig_branch  (sig_branch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [4:0] sh, input logic [15:0] imm);
        @(negedge clk);
        opcode      = op;
        ALU_control = fn;
        rs_content  = rs;
        rt_content  = rt;
        shamt       = sh;
        immediate   = imm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        opcode = 6'b000100; ALU_control = 6'h0; rs_content = 32'd15;
        rt_content = 32'd15; shamt = 5'd0; immediate = 16'h0;
        #2;
        checks++;
        if (ALU_result !== 32'h0 || sig_branch !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got %h/%b expected 00000000/0", ALU_result, sig_branch);
        end
        tick(); tick();
        checks++;
        if (ALU_result !== 32'h0 || sig_branch !== 1'b0) begin
            errors++;
            $display("FAIL reset_held got %h/%b expected 00000000/0", ALU_result, sig_branch);
        end
        // Release between edges; beq 15,15 must be captured on the very next edge.
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if (ALU_result !== 32'h0 || sig_branch !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_capture got %h/%b expected 00000000/1", ALU_result, sig_branch);
        end
    endtask

    task automatic test_branch();
        vec_t t[4];
        t = '{
            '{6'b000100, 6'h00, 32'd15, 32'd12, 5'd0, 16'h0, 32'd3,         1'b0},
            '{6'b000100, 6'h00, 32'd15, 32'd15, 5'd0, 16'h0, 32'd0,         1'b1},
            '{6'b000100, 6'h00, 32'd5,  32'd15, 5'd0, 16'h0, 32'hFFFFFFF6,  1'b0},
            '{6'b000101, 6'h00, 32'd5,  32'd15, 5'd0, 16'h0, 32'hFFFFFFF6,  1'b1}
        };
        foreach (t[i]) begin
            drive(t[i].op, t[i].fn, t[i].rs, t[i].rt, t[i].sh, t[i].imm);
            tick();
            checks++;
            if (ALU_result !== t[i].res) begin
                errors++;
                $display("FAIL branch[%0d] result got %h expected %h", i, ALU_result, t[i].res);
            end
            checks++;
            if (sig_branch !== t[i].br) begin
                errors++;
                $display("FAIL branch[%0d] sig_branch got %b expected %b", i, sig_branch, t[i].br);
            end
        end
    endtask

    task automatic test_rtype();
        vec_t t[16];
        t = '{
            '{6'h00, 6'b100001, 32'hFFFFFFFF, 32'h00000002, 5'd0, 16'h0, 32'h00000001, 1'b0},
            '{6'h00, 6'b100010, 32'h00000003, 32'h00000005, 5'd0, 16'h0, 32'hFFFFFFFE, 1'b0},
            '{6'h00, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 16'h0, 32'hF000F000, 1'b0},
            '{6'h00, 6'b100101, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 16'h0, 32'hFFF0FFF0, 1'b0},
            '{6'h00, 6'b100110, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 16'h0, 32'h0FF00FF0, 1'b0},
            '{6'h00, 6'b100111, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 16'h0, 32'h000F000F, 1'b0},
            '{6'h00, 6'b000011, 32'h0,        32'h80000000, 5'd4, 16'h0, 32'hF8000000, 1'b0},
            '{6'h00, 6'b000010, 32'h0,        32'h80000000, 5'd4, 16'h0, 32'h08000000, 1'b0},
            '{6'h00, 6'b000000, 32'h0,        32'h80000001, 5'd1, 16'h0, 32'h00000002, 1'b0},
            '{6'h00, 6'b000000, 32'h0,        32'hDEADBEEF, 5'd0, 16'h0, 32'hDEADBEEF, 1'b0},
            '{6'h00, 6'b000011, 32'h0,        32'hDEADBEEF, 5'd0, 16'h0, 32'hDEADBEEF, 1'b0},
            '{6'h00, 6'b101010, 32'h80000000, 32'h00000001, 5'd0, 16'h0, 32'h00000001, 1'b0},
            '{6'h00, 6'b101011, 32'h80000000, 32'h00000001, 5'd0, 16'h0, 32'h00000000, 1'b0},
            '{6'h00, 6'b101010, 32'h80000000, 32'h7FFFFFFF, 5'd0, 16'h0, 32'h00000001, 1'b0},
            '{6'h00, 6'b101011, 32'h80000000, 32'h7FFFFFFF, 5'd0, 16'h0, 32'h00000000, 1'b0},
            '{6'h00, 6'b101011, 32'h00000001, 32'h80000000, 5'd0, 16'h0, 32'h00000001, 1'b0}
        };
        foreach (t[i]) begin
            drive(t[i].op, t[i].fn, t[i].rs, t[i].rt, t[i].sh, t[i].imm);
            tick();
            checks++;
            if (ALU_result !== t[i].res || sig_branch !== t[i].br) begin
                errors++;
                $display("FAIL rtype[%0d] got %h/%b expected %h/%b", i, ALU_result, sig_branch, t[i].res, t[i].br);
            end
        end
    endtask

    task automatic test_itype();
        vec_t t[11];
        t = '{
            '{6'b001000, 6'h00, 32'd10,       32'h0, 5'd0, 16'hFFFF, 32'd9,        1'b0},
            '{6'b001001, 6'h00, 32'hFFFFFFFF, 32'h0, 5'd0, 16'h0001, 32'h00000000, 1'b0},
            '{6'b001101, 6'h00, 32'h0,        32'h0, 5'd0, 16'hFFFF, 32'h0000FFFF, 1'b0},
            '{6'b001111, 6'h00, 32'h0,        32'h0, 5'd0, 16'h1234, 32'h12340000, 1'b0},
            '{6'b001010, 6'h00, 32'd5,        32'h0, 5'd0, 16'hFFFF, 32'h00000000, 1'b0},
            '{6'b001011, 6'h00, 32'd5,        32'h0, 5'd0, 16'hFFFF, 32'h00000001, 1'b0},
            '{6'b001010, 6'h00, 32'hFFFFFFFE, 32'h0, 5'd0, 16'hFFFF, 32'h00000001, 1'b0},
            '{6'b001100, 6'h00, 32'hFFFFFFFF, 32'h0, 5'd0, 16'h8000, 32'h00008000, 1'b0},
            '{6'b001110, 6'h00, 32'h0000FFFF, 32'h0, 5'd0, 16'h00FF, 32'h0000FF00, 1'b0},
            '{6'b100011, 6'h00, 32'h00001000, 32'h0, 5'd0, 16'hFFFC, 32'h00000FFC, 1'b0},
            '{6'b101011, 6'h00, 32'h00001000, 32'h0, 5'd0, 16'h0010, 32'h00001010, 1'b0}
        };
        foreach (t[i]) begin
            drive(t[i].op, t[i].fn, t[i].rs, t[i].rt, t[i].sh, t[i].imm);
            tick();
            checks++;
            if (ALU_result !== t[i].res || sig_branch !== t[i].br) begin
                errors++;
                $display("FAIL itype[%0d] got %h/%b expected %h/%b", i, ALU_result, sig_branch, t[i].res, t[i].br);
            end
        end
    endtask

    task automatic test_unlisted();
        // Start from a taken branch so stale nonzero outputs would show.
        drive(6'b000101, 6'h00, 32'd1, 32'd2, 5'd0, 16'h0);
        tick();
        drive(6'b111111, 6'h00, 32'd7, 32'd3, 5'd2, 16'hFFFF);
        tick();
        checks++;
        if (ALU_result !== 32'h0 || sig_branch !== 1'b0) begin
            errors++;
            $display("FAIL unlisted_opcode got %h/%b expected 00000000/0", ALU_result, sig_branch);
        end
        drive(6'b000101, 6'h00, 32'd1, 32'd2, 5'd0, 16'h0);
        tick();
        drive(6'b000000, 6'b001111, 32'd7, 32'd3, 5'd2, 16'h0);
        tick();
        checks++;
        if (ALU_result !== 32'h0 || sig_branch !== 1'b0) begin
            errors++;
            $display("FAIL unlisted_funct got %h/%b expected 00000000/0", ALU_result, sig_branch);
        end
        drive(6'b001000, 6'h00, 32'd1, 32'd1, 5'd0, 16'h0001);
        tick();
        checks++;
        if (ALU_result !== 32'd2 || sig_branch !== 1'b0) begin
            errors++;
            $display("FAIL nonbranch_flag got %h/%b expected 00000002/0", ALU_result, sig_branch);
        end
    endtask

    task automatic test_var_shift();
        vec_t t[3];
`ifdef ALU_VAR_SHIFT_EN
        t = '{
            '{6'h00, 6'b000100, 32'd35, 32'h00000001, 5'd7, 16'h0, 32'h00000008, 1'b0},
            '{6'h00, 6'b000111, 32'd4,  32'h80000000, 5'd0, 16'h0, 32'hF8000000, 1'b0},
            '{6'h00, 6'b000110, 32'd36, 32'h80000000, 5'd0, 16'h0, 32'h08000000, 1'b0}
        };
`else
        t = '{
            '{6'h00, 6'b000100, 32'd35, 32'h00000001, 5'd7, 16'h0, 32'h00000000, 1'b0},
            '{6'h00, 6'b000111, 32'd4,  32'h80000000, 5'd0, 16'h0, 32'h00000000, 1'b0},
            '{6'h00, 6'b000110, 32'd36, 32'h80000000, 5'd0, 16'h0, 32'h00000000, 1'b0}
        };
`endif
        foreach (t[i]) begin
            drive(t[i].op, t[i].fn, t[i].rs, t[i].rt, t[i].sh, t[i].imm);
            tick();
            checks++;
            if (ALU_result !== t[i].res || sig_branch !== t[i].br) begin
                errors++;
                $display("FAIL varshift[%0d] got %h/%b expected %h/%b", i, ALU_result, sig_branch, t[i].res, t[i].br);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(6'b000101, 6'h00, 32'd5, 32'd15, 5'd0, 16'h0);
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ALU_result !== 32'h0 || sig_branch !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_midcycle got %h/%b expected 00000000/0", ALU_result, sig_branch);
        end
        // Hold reset across an edge: the pending bne result must be discarded.
        tick();
        #2;
        rst = 1'b0;
        checks++;
        if (ALU_result !== 32'h0 || sig_branch !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_discard got %h/%b expected 00000000/0", ALU_result, sig_branch);
        end
        tick();
        checks++;
        if (ALU_result !== 32'hFFFFFFF6 || sig_branch !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_recover got %h/%b expected fffffff6/1", ALU_result, sig_branch);
        end
    endtask

    task automatic test_back_to_back();
        drive(6'b001111, 6'h00, 32'h0, 32'h0, 5'd0, 16'hABCD);
        tick();
        checks++;
        if (ALU_result !== 32'hABCD0000) begin
            errors++;
            $display("FAIL b2b_first got %h expected abcd0000", ALU_result);
        end
        drive(6'b000000, 6'b100000, 32'd100, 32'd23, 5'd0, 16'h0);
        #1;
        checks++;
        if (ALU_result !== 32'hABCD0000) begin
            errors++;
            $display("FAIL b2b_hold got %h expected abcd0000", ALU_result);
        end
        tick();
        checks++;
        if (ALU_result !== 32'd123) begin
            errors++;
            $display("FAIL b2b_second got %h expected 0000007b", ALU_result);
        end
        drive(6'b000100, 6'h00, 32'd9, 32'd9, 5'd0, 16'h0);
        tick();
        checks++;
        if (ALU_result !== 32'd0 || sig_branch !== 1'b1) begin
            errors++;
            $display("FAIL b2b_third got %h/%b expected 00000000/1", ALU_result, sig_branch);
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_rtype();
        test_itype();
        test_unlisted();
        test_var_shift();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
